// File: rtl/serial_addsub_64.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle goes through a full-adder
// ripple chain, and the carry between slices is kept in a register.
`timescale 1ns/1ps
module serial_addsub_64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero
);
    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned OFF_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_flag;
    logic             r_ovf;
    logic             r_zero;

    logic [OFF_W-1:0] w_base;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_sum;
    logic [CHUNK:0]   w_c;
    logic [WIDTH-1:0] w_result_next;
    logic             w_last;

    assign w_base = OFF_W'(r_cnt) * OFF_W'(CHUNK);
    assign w_a    = r_op_a[w_base +: CHUNK];
    assign w_b    = r_op_b[w_base +: CHUNK];
    assign w_last = (r_cnt == LAST_CNT);

    // Ripple chain of full-adder cells; w_c[i] is the carry into bit i of the slice.
    assign w_c[0] = r_carry;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign w_sum[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i + 1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end

    // Zero must see the slice being written this cycle, so build the completed value here.
    always_comb begin
        w_result_next                    = r_result;
        w_result_next[w_base +: CHUNK]   = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_carry_flag <= 1'b0;
            r_ovf        <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op_a       <= A;
                        r_op_b       <= SUB ? ~B : B;
                        r_carry      <= SUB;
                        r_cnt        <= '0;
                        r_result     <= '0;
                        r_carry_flag <= 1'b0;
                        r_ovf        <= 1'b0;
                        r_zero       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= StRun;
                    end
                end
                StRun: begin
                    r_result <= w_result_next;
                    r_carry  <= w_c[CHUNK];
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_carry_flag <= w_c[CHUNK];
                        r_ovf        <= w_c[CHUNK] ^ w_c[CHUNK-1];
                        r_zero       <= (w_result_next == '0);
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign Result   = r_result;
    assign Carry    = r_carry_flag;
    assign Overflow = r_ovf;
    assign Zero     = r_zero;

endmodule

// File: tb/tb_serial_addsub_64.sv
// Directed and randomised checks of serial_addsub_64: vector table, reset abort,
// back-to-back handshake and a golden-model sweep.
`timescale 1ns/1ps
module tb_serial_addsub_64;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        SUB;
    logic [63:0] A;
    logic [63:0] B;
    logic        busy;
    logic        done;
    logic [63:0] Result;
    logic        Carry;
    logic        Overflow;
    logic        Zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_addsub_64 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .SUB      (SUB),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .Carry    (Carry),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Independent reference: {carry, overflow, zero, result}.
    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic sub);
        logic [63:0] bb;
        logic [64:0] s;
        logic        v;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
        v  = (a[63] == bb[63]) && (s[63] != a[63]);
        return {s[64], v, (s[63:0] == 64'd0), s[63:0]};
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".latency"}, 64'(n), 64'(N));
    endtask

    task automatic check_result(input string name, input logic [63:0] res, input logic c,
                                input logic v, input logic z);
        check({name, ".Result"}, Result, res);
        check1({name, ".Carry"}, Carry, c);
        check1({name, ".Overflow"}, Overflow, v);
        check1({name, ".Zero"}, Zero, z);
        check1({name, ".busy_low"}, busy, 1'b0);
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [63:0] res, input logic c,
                          input logic v, input logic z);
        start = 1'b1;
        A     = a;
        B     = b;
        SUB   = sub;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        SUB   = ~sub;
        check1({name, ".busy"}, busy, 1'b1);
        check({name, ".cleared"}, Result, 64'd0);
        wait_done(name);
        check_result(name, res, c, v, z);
        @(posedge clk);
        #1;
        check1({name, ".done_pulse"}, done, 1'b0);
        check({name, ".held"}, Result, res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] h_a[3];
        logic [63:0] h_b[3];
        logic        h_s[3];
        logic [63:0] h_r[3];
        logic        h_c[3];
        logic [66:0] m;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        int          seen;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000,
                    1'b0, 1'b1, 1'b0};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b1, 1'b0};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                    64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,
                    1'b1, 1'b1, 1'b1};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,
                    1'b1, 1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        SUB   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("reset.busy", busy, 1'b0);
        check1("reset.done", done, 1'b0);
        check("reset.Result", Result, 64'd0);
        check1("reset.Carry", Carry, 1'b0);
        check1("reset.Overflow", Overflow, 1'b0);
        check1("reset.Zero", Zero, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check1("idle.busy", busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res,
                   vecs[i].c, vecs[i].v, vecs[i].z);
        end

        // Reset in the middle of an operation.
        start = 1'b1;
        A     = 64'h1;
        B     = 64'h1;
        SUB   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("abort.busy", busy, 1'b0);
        check1("abort.done", done, 1'b0);
        check("abort.Result", Result, 64'd0);
        check1("abort.Carry", Carry, 1'b0);
        check1("abort.Overflow", Overflow, 1'b0);
        check1("abort.Zero", Zero, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort.no_done", 64'(seen), 64'd0);
        run_op("after_abort", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0);

        // start held high: each op must use only its acceptance-cycle operands.
        h_a = '{64'h1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF};
        h_b = '{64'h2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        h_s = '{1'b0, 1'b1, 1'b0};
        h_r = '{64'h3, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE};
        h_c = '{1'b0, 1'b1, 1'b1};
        start = 1'b1;
        A     = h_a[0];
        B     = h_b[0];
        SUB   = h_s[0];
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j < 2) begin
                A   = h_a[j+1];
                B   = h_b[j+1];
                SUB = h_s[j+1];
            end else begin
                start = 1'b0;
                A     = '1;
                B     = '0;
                SUB   = 1'b1;
            end
            wait_done($sformatf("hs%0d", j));
            check_result($sformatf("hs%0d", j), h_r[j], h_c[j], 1'b0, 1'b0);
            @(posedge clk);
            #1;
            check1($sformatf("hs%0d.done_pulse", j), done, 1'b0);
            check1($sformatf("hs%0d.next_busy", j), busy, (j < 2));
            check($sformatf("hs%0d.after", j), Result, (j < 2) ? 64'd0 : h_r[j]);
        end

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom(), $urandom()};
            rb = (i % 10 == 0) ? ra : {$urandom(), $urandom()};
            rs = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rs = 1'b1;
            m = model(ra, rb, rs);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, m[63:0], m[66], m[65], m[64]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
